// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG AC entropy-coding stage.
//   - AC symbol constants (EOB, ZRL), last zigzag index, amplitude limit
//   - FSM state encoding for the AC run-length sequencer
//   - Output symbol record (Huffman code + amplitude bits + block-end flag)
//   - bit_len10: number of significant bits in a 10-bit magnitude (SSSS)
package jpeg_pkg;

  localparam logic [7:0] AC_EOB      = 8'h00;
  localparam logic [7:0] AC_ZRL      = 8'hF0;
  localparam logic [5:0] AC_LAST_IDX = 6'd63;
  localparam int         AMP_MAX     = 1023;

  typedef enum logic [1:0] {S_RUN, S_ZRL, S_SYM, S_EOB} ac_state_t;

  typedef struct packed {
    logic [15:0] code;
    logic [4:0]  code_len;
    logic [9:0]  amp;
    logic [3:0]  amp_len;
    logic        eob;
  } ac_sym_t;

  function automatic logic [3:0] bit_len10(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) n = 4'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/ac_lut.sv
// Standard JPEG luminance AC Huffman table (ITU T.81 Annex K.5).
//   sym      in  8   RRRR/SSSS symbol
//   code     out 16  Huffman code, right-aligned (0 for symbols not in table)
//   code_len out 5   code bit count (0 for symbols not in table)
// The table is held as the canonical BITS/HUFFVAL pair; codes are assigned
// in canonical order by the loop below, which folds to constants.
module ac_lut (
  input  logic [7:0]  sym,
  output logic [15:0] code,
  output logic [4:0]  code_len
);

  // Number of codes of each length 1..16; length 1 occupies the top byte.
  localparam logic [16*8-1:0] BITS_V = {
    8'd0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd4, 8'd3,
    8'd5, 8'd5, 8'd4, 8'd4, 8'd0, 8'd0, 8'd1, 8'd125
  };

  // Symbols in order of increasing code; entry 0 occupies the top byte.
  localparam logic [162*8-1:0] HUFFVAL_V = {
    8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12,
    8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
    8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'ha1, 8'h08,
    8'h23, 8'h42, 8'hb1, 8'hc1, 8'h15, 8'h52, 8'hd1, 8'hf0,
    8'h24, 8'h33, 8'h62, 8'h72, 8'h82, 8'h09, 8'h0a, 8'h16,
    8'h17, 8'h18, 8'h19, 8'h1a, 8'h25, 8'h26, 8'h27, 8'h28,
    8'h29, 8'h2a, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
    8'h3a, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
    8'h4a, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59,
    8'h5a, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
    8'h6a, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79,
    8'h7a, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
    8'h8a, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98,
    8'h99, 8'h9a, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
    8'ha8, 8'ha9, 8'haa, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6,
    8'hb7, 8'hb8, 8'hb9, 8'hba, 8'hc2, 8'hc3, 8'hc4, 8'hc5,
    8'hc6, 8'hc7, 8'hc8, 8'hc9, 8'hca, 8'hd2, 8'hd3, 8'hd4,
    8'hd5, 8'hd6, 8'hd7, 8'hd8, 8'hd9, 8'hda, 8'he1, 8'he2,
    8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 8'he8, 8'he9, 8'hea,
    8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7, 8'hf8,
    8'hf9, 8'hfa
  };

  int          lvl;
  int          used;
  logic [16:0] acc;

  // Canonical assignment: codes count up within a length; moving to the
  // next length appends a zero bit (shift left).
  always_comb begin
    code     = '0;
    code_len = '0;
    lvl      = 1;
    used     = 0;
    acc      = '0;
    for (int k = 0; k < 162; k++) begin
      for (int s = 0; s < 16; s++) begin
        if (lvl < 16 && used == int'(BITS_V[(16 - lvl) * 8 +: 8])) begin
          acc  = acc << 1;
          lvl  = lvl + 1;
          used = 0;
        end
      end
      if (HUFFVAL_V[(161 - k) * 8 +: 8] == sym) begin
        code     = acc[15:0];
        code_len = 5'(lvl);
      end
      acc  = acc + 17'd1;
      used = used + 1;
    end
  end

endmodule

// File: rtl/ac_size_amp.sv
// Magnitude category and amplitude bits for one AC coefficient.
//   coef  in  COEF_W  signed coefficient (two's complement)
//   ssss  out 4       bit length of |coef| after clamping to +/-1023 (0..10)
//   amp   out 10      amplitude bits, right-aligned, low ssss bits valid:
//                     coef for positive values, coef-1 for negative values
module ac_size_amp
  import jpeg_pkg::*;
#(
  parameter int COEF_W = 12
) (
  input  logic signed [COEF_W-1:0] coef,
  output logic        [3:0]        ssss,
  output logic        [9:0]        amp
);

  function automatic logic signed [10:0] sat_coef(input logic signed [COEF_W-1:0] c);
    logic signed [31:0] ci;
    logic signed [10:0] r;
    ci = c;
    if (ci > AMP_MAX)       r = 11'sd1023;
    else if (ci < -AMP_MAX) r = -11'sd1023;
    else                    r = ci[10:0];
    return r;
  endfunction

  logic signed [10:0] cl;
  logic signed [10:0] neg;
  logic signed [10:0] amp_raw;
  logic        [9:0]  mag;
  logic        [10:0] mask;

  always_comb begin
    cl      = sat_coef(coef);
    neg     = -cl;
    mag     = cl[10] ? neg[9:0] : cl[9:0];
    ssss    = bit_len10(mag);
    // Negative values use the one's complement form, i.e. coef-1.
    amp_raw = cl[10] ? (cl - 11'sd1) : cl;
    mask    = (11'd1 << ssss) - 11'd1;
    amp     = amp_raw[9:0] & mask[9:0];
  end

endmodule

// File: rtl/ac_rle_ctrl.sv
// AC run-length sequencer for the JPEG entropy coder.
// Accepts the 63 zigzag-ordered AC coefficients of a block, counts zero
// runs and emits one Huffman symbol per output handshake, inserting ZRL
// (0xF0) for runs of 16+ zeros and EOB (0x00) for a trailing zero tail.
//   clk, rst_n       clock, asynchronous active-low reset
//   clr              synchronous abort of the current block
//   in_valid/ready   coefficient handshake, in_coef signed COEF_W bits
//   out_valid/ready  symbol handshake
//   out_code/_len    Huffman code (right-aligned) and its length
//   out_amp/_len     amplitude bits (right-aligned) and their count
//   out_eob          last symbol of the block
module ac_rle_ctrl
  import jpeg_pkg::*;
#(
  parameter int COEF_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [15:0]       out_code,
  output logic        [4:0]        out_code_len,
  output logic        [9:0]        out_amp,
  output logic        [3:0]        out_amp_len,
  output logic                     out_eob
);

  ac_state_t   state, state_nxt;
  logic [5:0]  idx, idx_nxt;
  logic [5:0]  run, run_nxt;
  logic [1:0]  zrl_cnt, zrl_nxt;
  logic [3:0]  rrrr, rrrr_nxt;
  logic [3:0]  ssss, ssss_nxt;
  logic [9:0]  amp, amp_nxt;
  ac_sym_t     sym_p1, sym_nxt;
  logic        vld_p1, vld_nxt;
  logic        rdy_en;

  logic [3:0]  coef_ssss;
  logic [9:0]  coef_amp;
  logic [7:0]  lut_sym;
  logic [15:0] lut_code;
  logic [4:0]  lut_len;
  logic        slot_free;
  logic        accept;

  ac_size_amp #(.COEF_W(COEF_W)) u_size_amp (
    .coef (in_coef),
    .ssss (coef_ssss),
    .amp  (coef_amp)
  );

  always_comb begin
    case (state)
      S_ZRL:   lut_sym = AC_ZRL;
      S_EOB:   lut_sym = AC_EOB;
      default: lut_sym = {rrrr, ssss};
    endcase
  end

  ac_lut u_lut (
    .sym      (lut_sym),
    .code     (lut_code),
    .code_len (lut_len)
  );

  // A new symbol may load when the slot is empty or drains this cycle.
  assign slot_free = !vld_p1 || out_ready;
  // rdy_en keeps in_ready low until the first clock after reset release.
  assign in_ready  = rdy_en && (state == S_RUN) && slot_free;
  assign accept    = in_valid && in_ready && !clr;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    run_nxt   = run;
    zrl_nxt   = zrl_cnt;
    rrrr_nxt  = rrrr;
    ssss_nxt  = ssss;
    amp_nxt   = amp;
    sym_nxt   = sym_p1;
    vld_nxt   = vld_p1;

    if (vld_p1 && out_ready) vld_nxt = 1'b0;

    unique case (state)
      S_RUN: begin
        if (accept) begin
          if (in_coef == '0) begin
            // Zeros pending at the last index collapse into a single EOB.
            if (idx == AC_LAST_IDX) begin
              state_nxt = S_EOB;
            end else begin
              run_nxt = run + 6'd1;
              idx_nxt = idx + 6'd1;
            end
          end else begin
            zrl_nxt   = run[5:4];
            rrrr_nxt  = run[3:0];
            ssss_nxt  = coef_ssss;
            amp_nxt   = coef_amp;
            run_nxt   = '0;
            state_nxt = (run[5:4] != 2'd0) ? S_ZRL : S_SYM;
          end
        end
      end
      S_ZRL: begin
        if (slot_free) begin
          sym_nxt = '{code: lut_code, code_len: lut_len, amp: '0, amp_len: '0, eob: 1'b0};
          vld_nxt = 1'b1;
          zrl_nxt = zrl_cnt - 2'd1;
          if (zrl_cnt == 2'd1) state_nxt = S_SYM;
        end
      end
      S_SYM: begin
        if (slot_free) begin
          // A nonzero coefficient at the last index ends the block itself.
          sym_nxt   = '{code: lut_code, code_len: lut_len, amp: amp, amp_len: ssss,
                        eob: (idx == AC_LAST_IDX)};
          vld_nxt   = 1'b1;
          idx_nxt   = (idx == AC_LAST_IDX) ? 6'd1 : idx + 6'd1;
          state_nxt = S_RUN;
        end
      end
      S_EOB: begin
        if (slot_free) begin
          sym_nxt   = '{code: lut_code, code_len: lut_len, amp: '0, amp_len: '0, eob: 1'b1};
          vld_nxt   = 1'b1;
          idx_nxt   = 6'd1;
          run_nxt   = '0;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase

    if (clr) begin
      state_nxt = S_RUN;
      idx_nxt   = 6'd1;
      run_nxt   = '0;
      zrl_nxt   = '0;
      sym_nxt   = '0;
      vld_nxt   = 1'b0;
    end
  end

  // Stage p1: registered output symbol and sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RUN;
      idx     <= 6'd1;
      run     <= '0;
      zrl_cnt <= '0;
      rrrr    <= '0;
      ssss    <= '0;
      amp     <= '0;
      sym_p1  <= '0;
      vld_p1  <= 1'b0;
      rdy_en  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      run     <= run_nxt;
      zrl_cnt <= zrl_nxt;
      rrrr    <= rrrr_nxt;
      ssss    <= ssss_nxt;
      amp     <= amp_nxt;
      sym_p1  <= sym_nxt;
      vld_p1  <= vld_nxt;
      rdy_en  <= 1'b1;
    end
  end

  assign out_valid    = vld_p1;
  assign out_code     = sym_p1.code;
  assign out_code_len = sym_p1.code_len;
  assign out_amp      = sym_p1.amp;
  assign out_amp_len  = sym_p1.amp_len;
  assign out_eob      = sym_p1.eob;

endmodule

// File: tb/tb_ac_rle_ctrl.sv
// Directed bench for ac_rle_ctrl: whole blocks are fed coefficient by
// coefficient, accepted symbols are collected and compared with
// hand-derived JPEG luminance AC codes.
module tb_ac_rle_ctrl;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [11:0] in_coef = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       out_code;
  logic [4:0]        out_code_len;
  logic [9:0]        out_amp;
  logic [3:0]        out_amp_len;
  logic              out_eob;

  int passed = 0;
  int total  = 0;

  logic [35:0]        capq [$];
  logic signed [11:0] blk [1:63];

  ac_rle_ctrl #(.COEF_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_coef      (in_coef),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_code_len (out_code_len),
    .out_amp      (out_amp),
    .out_amp_len  (out_amp_len),
    .out_eob      (out_eob)
  );

  always #5 clk = ~clk;

  // Inputs change only 1ns after a rising edge, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n && !clr && out_valid && out_ready)
      capq.push_back({out_code, out_code_len, out_amp, out_amp_len, out_eob});
  end

  function automatic logic [35:0] mk(input logic [15:0] c, input int l,
                                     input logic [9:0] a, input int al, input logic e);
    return {c, 5'(l), a, 4'(al), e};
  endfunction

  task automatic clear_blk();
    for (int i = 1; i <= 63; i++) blk[i] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [11:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_coef  = c;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      total++;
      $display("FAIL send_timeout in_ready stayed 0, required 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_blk();
    for (int i = 1; i <= 63; i++) send(blk[i]);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid);
    else passed++;
    total++;
    if ({out_code, out_code_len, out_amp, out_amp_len, out_eob} !== 36'h0)
      $display("FAIL reset_out_fields got %h exp 0",
               {out_code, out_code_len, out_amp, out_amp_len, out_eob});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b exp 1", in_ready);
    else passed++;
  endtask

  task automatic test_all_zero();
    logic [35:0] got;
    capq.delete();
    clear_blk();
    send_blk();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL allzero_latency0 got out_valid %b exp 0", out_valid);
    else passed++;
    @(negedge clk);
    total++;
    if ({out_valid, out_code, out_code_len, out_eob} !== {1'b1, 16'h000A, 5'd4, 1'b1})
      $display("FAIL allzero_latency1 got %h exp %h",
               {out_valid, out_code, out_code_len, out_eob}, {1'b1, 16'h000A, 5'd4, 1'b1});
    else passed++;
    idle(6);
    total++;
    if (capq.size() !== 1) $display("FAIL allzero_count got %0d exp 1", capq.size());
    else passed++;
    got = (capq.size() > 0) ? capq[0] : 'x;
    total++;
    if (got !== mk(16'h000A, 4, 10'd0, 0, 1'b1))
      $display("FAIL allzero_eob got %h exp %h", got, mk(16'h000A, 4, 10'd0, 0, 1'b1));
    else passed++;
  endtask

  task automatic test_single();
    logic [35:0] want [2];
    logic [35:0] got;
    want[0] = mk(16'h0004, 3, 10'd5, 3, 1'b0);
    want[1] = mk(16'h000A, 4, 10'd0, 0, 1'b1);
    capq.delete();
    clear_blk();
    blk[1] = 12'sd5;
    send_blk();
    idle(6);
    total++;
    if (capq.size() !== 2) $display("FAIL single_count got %0d exp 2", capq.size());
    else passed++;
    for (int i = 0; i < 2; i++) begin
      got = (i < capq.size()) ? capq[i] : 'x;
      total++;
      if (got !== want[i]) $display("FAIL single_sym%0d got %h exp %h", i, got, want[i]);
      else passed++;
    end
  endtask

  task automatic test_zrl_neg();
    logic [35:0] want [3];
    logic [35:0] got;
    want[0] = mk(16'h07F9, 11, 10'd0, 0, 1'b0);
    want[1] = mk(16'h03F8, 10, 10'd0, 2, 1'b0);
    want[2] = mk(16'h000A, 4, 10'd0, 0, 1'b1);
    capq.delete();
    clear_blk();
    blk[21] = -12'sd3;
    send_blk();
    idle(6);
    total++;
    if (capq.size() !== 3) $display("FAIL zrlneg_count got %0d exp 3", capq.size());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      got = (i < capq.size()) ? capq[i] : 'x;
      total++;
      if (got !== want[i]) $display("FAIL zrlneg_sym%0d got %h exp %h", i, got, want[i]);
      else passed++;
    end
  endtask

  // Last-index nonzero ends the block; the following all-zero block must
  // start again at index 1 and produce a single EOB.
  task automatic test_back_to_back();
    logic [35:0] want [5];
    logic [35:0] got;
    for (int i = 0; i < 3; i++) want[i] = mk(16'h07F9, 11, 10'd0, 0, 1'b0);
    want[3] = mk(16'hFFEB, 16, 10'd1, 1, 1'b1);
    want[4] = mk(16'h000A, 4, 10'd0, 0, 1'b1);
    capq.delete();
    clear_blk();
    blk[63] = 12'sd1;
    send_blk();
    clear_blk();
    send_blk();
    idle(6);
    total++;
    if (capq.size() !== 5) $display("FAIL b2b_count got %0d exp 5", capq.size());
    else passed++;
    for (int i = 0; i < 5; i++) begin
      got = (i < capq.size()) ? capq[i] : 'x;
      total++;
      if (got !== want[i]) $display("FAIL b2b_sym%0d got %h exp %h", i, got, want[i]);
      else passed++;
    end
  endtask

  task automatic test_clamp();
    logic [35:0] want [2];
    logic [35:0] got;
    want[0] = mk(16'hFF83, 16, 10'd0, 10, 1'b0);
    want[1] = mk(16'h000A, 4, 10'd0, 0, 1'b1);
    capq.delete();
    clear_blk();
    blk[1] = -12'sd2000;
    send_blk();
    idle(6);
    total++;
    if (capq.size() !== 2) $display("FAIL clamp_count got %0d exp 2", capq.size());
    else passed++;
    for (int i = 0; i < 2; i++) begin
      got = (i < capq.size()) ? capq[i] : 'x;
      total++;
      if (got !== want[i]) $display("FAIL clamp_sym%0d got %h exp %h", i, got, want[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] want [4];
    logic [35:0] got;
    for (int i = 0; i < 3; i++) want[i] = mk(16'h07F9, 11, 10'd0, 0, 1'b0);
    want[3] = mk(16'hFFEB, 16, 10'd1, 1, 1'b1);
    capq.delete();
    for (int i = 1; i <= 62; i++) send(12'sd0);
    send(12'sd1);
    out_ready = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_code, out_code_len, in_ready} !== {1'b1, 16'h07F9, 5'd11, 1'b0})
        $display("FAIL stall_cycle%0d got %h exp %h", c,
                 {out_valid, out_code, out_code_len, in_ready}, {1'b1, 16'h07F9, 5'd11, 1'b0});
      else passed++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(8);
    total++;
    if (capq.size() !== 4) $display("FAIL stall_count got %0d exp 4", capq.size());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      got = (i < capq.size()) ? capq[i] : 'x;
      total++;
      if (got !== want[i]) $display("FAIL stall_sym%0d got %h exp %h", i, got, want[i]);
      else passed++;
    end
  endtask

  task automatic test_clr();
    logic [35:0] want [2];
    logic [35:0] got;
    want[0] = mk(16'h0004, 3, 10'd5, 3, 1'b0);
    want[1] = mk(16'h000A, 4, 10'd0, 0, 1'b1);
    capq.delete();
    send(12'sd0);
    send(12'sd0);
    send(12'sd7);
    send(12'sd0);
    idle(2);
    got = (capq.size() > 0) ? capq[0] : 'x;
    total++;
    if (got !== mk(16'h03F7, 10, 10'd7, 3, 1'b0))
      $display("FAIL preclr_sym got %h exp %h", got, mk(16'h03F7, 10, 10'd7, 3, 1'b0));
    else passed++;
    capq.delete();
    clr = 1'b1;
    in_valid = 1'b1;
    in_coef = 12'sd9;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    clear_blk();
    blk[1] = 12'sd5;
    send_blk();
    idle(6);
    total++;
    if (capq.size() !== 2) $display("FAIL clr_count got %0d exp 2", capq.size());
    else passed++;
    for (int i = 0; i < 2; i++) begin
      got = (i < capq.size()) ? capq[i] : 'x;
      total++;
      if (got !== want[i]) $display("FAIL clr_sym%0d got %h exp %h", i, got, want[i]);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic [35:0] got;
    capq.delete();
    for (int i = 1; i <= 62; i++) send(12'sd0);
    out_ready = 1'b0;
    send(12'sd1);
    idle(3);
    total++;
    if ({out_valid, out_code} !== {1'b1, 16'h07F9})
      $display("FAIL prerst_hold got %h exp %h", {out_valid, out_code}, {1'b1, 16'h07F9});
    else passed++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b00)
      $display("FAIL arst_valid_ready got %b exp 00", {out_valid, in_ready});
    else passed++;
    total++;
    if ({out_code, out_code_len, out_amp, out_amp_len, out_eob} !== 36'h0)
      $display("FAIL arst_fields got %h exp 0",
               {out_code, out_code_len, out_amp, out_amp_len, out_eob});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    capq.delete();
    clear_blk();
    send_blk();
    idle(6);
    total++;
    if (capq.size() !== 1) $display("FAIL postrst_count got %0d exp 1", capq.size());
    else passed++;
    got = (capq.size() > 0) ? capq[0] : 'x;
    total++;
    if (got !== mk(16'h000A, 4, 10'd0, 0, 1'b1))
      $display("FAIL postrst_eob got %h exp %h", got, mk(16'h000A, 4, 10'd0, 0, 1'b1));
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_zero();
    test_single();
    test_zrl_neg();
    test_back_to_back();
    test_clamp();
    test_backpressure();
    test_clr();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ac_rle_ctrl.md
Name: ac_rle_ctrl

Overview:
- Sequencer for the AC entropy-coding stage of the JPEG encoder.
- Consumes the 63 zigzag-ordered AC coefficients of one 8x8 block and tracks zero runs.
- Forms RRRR/SSSS symbols, drives the shared ac_lut table and emits one Huffman symbol per output handshake, including ZRL (0xF0) and EOB (0x00) insertion.
- Sits between the zigzag/quantiser output and the bit packer.

Parameters:
- COEF_W, 12, width of signed input coefficient (two's complement).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort; discards current block, returns to S_RUN with index 1.
- in_valid  in  1  coefficient valid.
- in_ready  out  1  coefficient accepted when in_valid&&in_ready.
- in_coef  in  COEF_W  signed AC coefficient, zigzag order, indices 1..63.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts symbol.
- out_code  out  16  Huffman code, right-aligned.
- out_code_len  out  5  code bit count (2..16).
- out_amp  out  10  amplitude bits, right-aligned.
- out_amp_len  out  4  amplitude bit count (0 for ZRL/EOB).
- out_eob  out  1  symbol is EOB or the block's final symbol; marks block end.

Behaviour:
- Reset (rst_n low, async): state=S_RUN, idx=1, run=0, zrl_cnt=0. All out_* = 0, in_ready=0 during reset and 1 from first clock after release.
- Magnitude: coefficients outside ±1023 clamp to ±1023.
  - SSSS = bit length of |coef| (0..10).
  - Amplitude = coef if positive, else (coef-1); keep low SSSS bits.
- Output register holds whenever out_valid && !out_ready. A new symbol loads only when the register is empty or is being accepted in that cycle.
- in_ready = (state==S_RUN) && (!out_valid || out_ready).
- States:
  - S_RUN: accept coefficient at idx.
    - Zero, idx<63: run++, idx++, no output.
    - Zero at idx=63: go to S_EOB. Pending zeros and ZRLs are dropped.
    - Nonzero: zrl_cnt=run>>4, rrrr=run[3:0], latch SSSS/amp, run=0. Go to S_ZRL if zrl_cnt>0, else S_SYM.
  - S_ZRL: emit symbol 0xF0 (amp_len 0) per output slot, zrl_cnt--. Go to S_SYM when zrl_cnt reaches 0 after issue.
  - S_SYM: emit {rrrr,ssss}, code from ac_lut, latched amp bits.
    - If latched idx=63: out_eob=1 (no EOB symbol), idx=1, go to S_RUN.
    - Else idx++, go to S_RUN.
  - S_EOB: emit 0x00 (code 1010, len 4) with out_eob=1, idx=1, run=0, go to S_RUN.
- ac_lut is driven combinationally from the latched rrrr/ssss (0xF0 / 0x00 in ZRL/EOB). Its outputs are registered into out_*.
- Latency: 1 cycle from the accepting edge (or previous symbol issue) to out_valid, given an empty output slot.
- Throughput: one symbol per cycle under continuous out_ready. One zero coefficient per cycle.
- Simultaneous clr with a handshake: clr wins. Input is not consumed; out_valid drops next cycle.
- Max ZRLs per block: 3 (run ≤ 62).
- idx wraps 63→1 only at block end. A block always ends with exactly one out_eob=1 symbol.

Decomposition:
- jpeg_pkg holds:
  - Constants AC_EOB=8'h00, AC_ZRL=8'hF0, AC_LAST_IDX=6'd63, AMP_MAX=1023.
  - typedef enum logic [1:0] {S_RUN, S_ZRL, S_SYM, S_EOB} ac_state_t.
  - typedef struct for the output symbol (code, code_len, amp, amp_len, eob).
- Sub-modules:
  - ac_lut is instantiated as is.
  - ac_size_amp is natural: combinational clamp, SSSS and amplitude from coef.

Test Plan:
- All-zero block, 63 zeros → exactly one symbol: code 4'b1010, len 4, amp_len 0, out_eob=1, after the 63rd accept.
- Block [5, 0×62] → symbol 0x03: code 3'b100/len 3, amp 3'b101/len 3; then EOB 1010/len 4 with out_eob.
- 20 zeros then -3, rest zero → ZRL code 11111111001/len 11; then 0x42 code 1111111000/len 10, amp 2'b00/len 2; then EOB.
- 62 zeros then +1 → 3× ZRL, then 0xE1 code 1111111111101011/len 16, amp 1'b1/len 1, out_eob=1. No EOB symbol; next block starts at idx 1.
- Coef -2000 at idx 1 → clamped: 0x0A code 1111111110000011/len 16, amp 10'b0000000000/len 10.
- Backpressure and control:
  - out_ready low 5 cycles mid-ZRL burst → out_* stable, in_ready=0, no symbol lost or duplicated.
  - clr mid-block → next symbols reflect only the new block.
  - rst_n pulse mid-burst → all outputs 0 immediately.
